// File: rtl/mdu_divider.sv
// mdu_divider: iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One request at a time through an in_valid/in_ready handshake. One selected
// result through an out_valid/out_ready handshake that supports backpressure.
// Optional build macro MDU_DIV_SPECIAL_BYPASS_EN: divide-by-zero and overflow
// requests skip the iteration loop and produce their result one edge after accept.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_zero;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_bmag;
    logic [2*WIDTH-1:0] r_work;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;

    // Request decode: sign handling and special-case detection on raw inputs.
    logic             w_accept;
    logic             w_signed_in;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_zero_in;
    logic             w_ovf_in;

    assign w_accept    = in_valid && (r_state == S_IDLE) && !flush;
    assign w_signed_in = ~in_op[0];
    assign w_a_neg     = w_signed_in & in_a[WIDTH-1];
    assign w_b_neg     = w_signed_in & in_b[WIDTH-1];
    // Negating MIN wraps back to MIN, which is the right unsigned magnitude.
    assign w_a_mag     = w_a_neg ? (~in_a + ONE) : in_a;
    assign w_b_mag     = w_b_neg ? (~in_b + ONE) : in_b;
    assign w_zero_in   = (in_b == '0);
    assign w_ovf_in    = w_signed_in && (in_a == MINV) && (in_b == '1);

    // One restoring step. The bit shifted out of the upper half is kept as a
    // carry so divisors with the MSB set still compare correctly.
    logic [WIDTH:0]     w_hi;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_step;

    assign w_hi   = r_work[2*WIDTH-1:WIDTH-1];
    assign w_diff = w_hi - {1'b0, r_bmag};
    assign w_ge   = (w_hi >= {1'b0, r_bmag});
    assign w_step = w_ge ? {w_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1}
                         : {r_work[2*WIDTH-2:0], 1'b0};

    // Sign fix-up of the magnitudes, special-case override and result select.
    logic             w_signed;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_res;

    assign w_signed = ~r_op[0];
    assign w_q_mag  = r_work[WIDTH-1:0];
    assign w_r_mag  = r_work[2*WIDTH-1:WIDTH];

    // Final quotient/remainder selection including the architectural specials.
    always_comb begin
        w_q = (w_signed && (r_sa ^ r_sb)) ? (~w_q_mag + ONE) : w_q_mag;
        w_r = (w_signed && r_sa) ? (~w_r_mag + ONE) : w_r_mag;
        if (r_zero) begin
            w_q = '1;
            w_r = r_a_orig;
        end else if (r_ovf) begin
            w_q = MINV;
            w_r = '0;
        end
        w_res = r_op[1] ? w_r : w_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef MDU_DIV_SPECIAL_BYPASS_EN
                    // Specials already know their answer: go straight to the
                    // result register stage without iterating.
                    w_next = (w_zero_in || w_ovf_in) ? S_FIX : S_CALC;
`else
                    w_next = S_CALC;
`endif
                end
            end
            S_CALC:  if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // Datapath: operand capture on accept, one iteration per CALC cycle,
    // result capture in FIX. The result register only changes in FIX, so it
    // stays stable while DONE waits on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_orig <= '0;
            r_bmag   <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= in_op;
                r_sa     <= w_a_neg;
                r_sb     <= w_b_neg;
                r_zero   <= w_zero_in;
                r_ovf    <= w_ovf_in;
                r_a_orig <= in_a;
                r_bmag   <= w_b_mag;
                r_work   <= {{WIDTH{1'b0}}, w_a_mag};
                r_cnt    <= '0;
            end else if (r_state == S_CALC && !flush) begin
                r_work <= w_step;
                r_cnt  <= r_cnt + CW'(1);
            end
            if (r_state == S_FIX && !flush) r_result <= w_res;
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;

endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: randomized and directed checks of mdu_divider against a
// plain-arithmetic reference of the RISC-V M-extension division rules.
module tb_mdu_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
`ifdef MDU_DIV_SPECIAL_BYPASS_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = W + 1;
`endif
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;

    int vectors = 0;
    int errors  = 0;

    mdu_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    // Reference: integer division with RISC-V special-case definitions.
    function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        longint sa, sb;
        if (b == '0) begin
            q = '1; r = a;
        end else if (!op[0]) begin
            if (a == MINV && b == '1) begin
                q = MINV; r = '0;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // Issue one request and check latency and value. Starts and ends just
    // after a negedge. When out_ready is low the result is left in DONE.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int exp_lat, input string nm);
        int lat;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready before issue: got %b want 1", nm, in_ready);
        end
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_op = 2'($urandom); in_a = W'($urandom); in_b = W'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        vectors++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
        end
        vectors++;
        if (out_result !== exp) begin
            errors++; $display("FAIL %s result a=%h b=%h op=%0d: got %h want %h", nm, a, b, op, out_result, exp);
        end
        if (out_ready) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL %s after transfer: in_ready=%b out_valid=%b want 1/0", nm, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0) begin
            errors++; $display("FAIL reset state: in_ready=%b out_valid=%b out_result=%h want 1/0/0", in_ready, out_valid, out_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(OP_DIVU, 32'd100, 32'd7, 32'h0000000E, W + 1, "divu_100_7");
        do_op(OP_REMU, 32'd100, 32'd7, 32'h00000002, W + 1, "remu_100_7");
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, W + 1, "div_m7_2");
        do_op(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, W + 1, "rem_m7_2");
        do_op(OP_REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, W + 1, "rem_7_m2");
        do_op(OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, W + 1, "divu_bigdiv");
    endtask

    task automatic test_special();
        do_op(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, SPEC_LAT, "div_by_zero");
        do_op(OP_REMU, 32'd5, 32'd0, 32'h00000005, SPEC_LAT, "remu_by_zero");
        do_op(OP_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, SPEC_LAT, "rem_neg_by_zero");
        do_op(OP_DIV, MINV, 32'hFFFFFFFF, MINV, SPEC_LAT, "div_ovf");
        do_op(OP_REM, MINV, 32'hFFFFFFFF, 32'h00000000, SPEC_LAT, "rem_ovf");
        do_op(OP_DIVU, MINV, 32'hFFFFFFFF, 32'h00000000, W + 1, "divu_min_ones");
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [W-1:0] a, b;
        logic special;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MINV; b = '1; end
                2: b = b >> $urandom_range(1, 31);
                3: a = a >> $urandom_range(1, 31);
                default: ;
            endcase
            special = (b == '0) || (!op[0] && a == MINV && b == '1);
            do_op(op, a, b, ref_div(op, a, b), special ? SPEC_LAT : W + 1, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        out_ready = 1'b0;
        do_op(OP_DIVU, 32'd1000, 32'd33, ref_div(OP_DIVU, 32'd1000, 32'd33), W + 1, "bp_issue");
        held = out_result;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held) begin
                errors++; $display("FAIL bp_hold cyc %0d: valid=%b ready=%b result=%h want 1/0/%h", c, out_valid, in_ready, out_result, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc0 = -1, acc1 = -1, nacc = 0, c = 0, lat = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd1000; in_b = 32'd10;
        while (nacc < 2 && c < 3 * W + 10) begin
            if (in_ready === 1'b1) begin
                if (nacc == 0) acc0 = c; else acc1 = c;
                nacc++;
            end
            @(posedge clk); @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        vectors++;
        if (acc1 - acc0 != W + 3) begin
            errors++; $display("FAIL b2b_interval: got %0d want %0d", acc1 - acc0, W + 3);
        end
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        vectors++;
        if (out_result !== 32'd100) begin
            errors++; $display("FAIL b2b_result: got %h want %h", out_result, 32'd100);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_flush();
        int seen = 0;
        // Flush colliding with a request in IDLE must drop the request.
        in_valid = 1'b1; flush = 1'b1; in_op = OP_DIVU; in_a = 32'd50; in_b = 32'd5;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle_accept: in_ready=%b want 1", in_ready);
        end
        for (int c = 0; c < W + 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_idle_novalid: out_valid cycles=%0d want 0", seen);
        end
        // Flush mid-iteration, after ten CALC steps.
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd77; in_b = 32'd7;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_calc: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_calc_novalid: out_valid cycles=%0d want 0", seen);
        end
        do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, W + 1, "after_flush_9_3");
    endtask

    task automatic test_reset_in_done();
        out_ready = 1'b0;
        do_op(OP_DIV, 32'hFFFFFF00, 32'd3, ref_div(OP_DIV, 32'hFFFFFF00, 32'd3), W + 1, "rst_done_issue");
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_result !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_done: valid=%b result=%h ready=%b want 0/0/1", out_valid, out_result, in_ready);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_in_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
